// File: rtl/riscv_dmarb.sv
// riscv_dmarb: shares the single data-memory port between the core LSU (port C)
// and the page-table walker (port P). Round-robin arbitration, one registered
// access per two cycles, and misaligned or out-of-range accesses are answered
// with an error without ever reaching the memory.
//
// Handshake: on each port, req is the valid and gnt is the ready. A transfer
// happens in a cycle where both are high. The requester holds req and its
// payload stable until it sees gnt. The response is a single-cycle rvalid pulse
// with err qualified by it and has no back-pressure. rdata is shared and
// belongs to whichever port's rvalid is high.
module riscv_dmarb #(
  parameter int MEM_SIZE = 64
) (
  input  logic        i_riscv_dmarb_clk,
  input  logic        i_riscv_dmarb_rst,
  input  logic        i_riscv_dmarb_c_req,
  input  logic        i_riscv_dmarb_p_req,
  input  logic        i_riscv_dmarb_c_we,
  input  logic        i_riscv_dmarb_p_we,
  input  logic [1:0]  i_riscv_dmarb_c_sel,
  input  logic [1:0]  i_riscv_dmarb_p_sel,
  input  logic [63:0] i_riscv_dmarb_c_addr,
  input  logic [63:0] i_riscv_dmarb_p_addr,
  input  logic [63:0] i_riscv_dmarb_c_wdata,
  input  logic [63:0] i_riscv_dmarb_p_wdata,
  output logic        o_riscv_dmarb_c_gnt,
  output logic        o_riscv_dmarb_p_gnt,
  output logic        o_riscv_dmarb_c_rvalid,
  output logic        o_riscv_dmarb_p_rvalid,
  output logic        o_riscv_dmarb_c_err,
  output logic        o_riscv_dmarb_p_err,
  output logic [63:0] o_riscv_dmarb_rdata,
  output logic        o_riscv_dmarb_dm_wen,
  output logic [1:0]  o_riscv_dmarb_dm_sel,
  output logic [63:0] o_riscv_dmarb_dm_addr,
  output logic [63:0] o_riscv_dmarb_dm_wdata,
  input  logic [63:0] i_riscv_dmarb_dm_rdata,
  output logic        o_riscv_dmarb_dbg_state
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam logic PORT_C = 1'b0;
  localparam logic PORT_P = 1'b1;

  state_t      state;
  logic        last;
  logic        req_we;
  logic [1:0]  req_sel;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        req_owner;

  logic        idle_ok;
  logic        gnt_c;
  logic        gnt_p;
  logic [3:0]  size_bytes;
  logic [64:0] end_addr;
  logic        mis;
  logic        rng;
  logic        err;

  // Error check on the registered request; 65-bit end address so a request
  // near the top of the address space cannot wrap back into range.
  always_comb begin
    size_bytes = 4'd1 << req_sel;
    end_addr   = {1'b0, req_addr} + {61'd0, size_bytes} - 65'd1;
    rng        = (end_addr >= 65'(MEM_SIZE));
    mis        = 1'b0;
    case (req_sel)
      2'b00: mis = 1'b0;
      2'b01: mis = req_addr[0];
      2'b10: mis = |req_addr[1:0];
      2'b11: mis = |req_addr[2:0];
    endcase
    err = mis | rng;
  end

  // Round-robin grant: only in IDLE, a lone requester always wins, and on
  // contention the port that was not granted last goes first.
  assign idle_ok = (state == IDLE) & ~i_riscv_dmarb_rst;
  assign gnt_c   = idle_ok & i_riscv_dmarb_c_req & (~i_riscv_dmarb_p_req | (last == PORT_P));
  assign gnt_p   = idle_ok & i_riscv_dmarb_p_req & (~i_riscv_dmarb_c_req | (last == PORT_C));

  assign o_riscv_dmarb_c_gnt = gnt_c;
  assign o_riscv_dmarb_p_gnt = gnt_p;

  // Memory port is driven straight from the request registers; the write is
  // suppressed on error and the moment reset is raised mid-access.
  assign o_riscv_dmarb_dm_addr   = req_addr;
  assign o_riscv_dmarb_dm_sel    = req_sel;
  assign o_riscv_dmarb_dm_wdata  = req_wdata;
  assign o_riscv_dmarb_dm_wen    = (state == ACCESS) & req_we & ~err & ~i_riscv_dmarb_rst;
  assign o_riscv_dmarb_dbg_state = (state == ACCESS);

  // Access sequencer: capture the granted request, run one ACCESS cycle, then
  // register the response and pulse the owner's rvalid.
  always_ff @(posedge i_riscv_dmarb_clk) begin
    if (i_riscv_dmarb_rst) begin
      state                  <= IDLE;
      last                   <= PORT_P;
      req_we                 <= 1'b0;
      req_sel                <= 2'b00;
      req_addr               <= 64'd0;
      req_wdata              <= 64'd0;
      req_owner              <= PORT_C;
      o_riscv_dmarb_c_rvalid <= 1'b0;
      o_riscv_dmarb_p_rvalid <= 1'b0;
      o_riscv_dmarb_c_err    <= 1'b0;
      o_riscv_dmarb_p_err    <= 1'b0;
      o_riscv_dmarb_rdata    <= 64'd0;
    end else begin
      o_riscv_dmarb_c_rvalid <= 1'b0;
      o_riscv_dmarb_p_rvalid <= 1'b0;
      o_riscv_dmarb_c_err    <= 1'b0;
      o_riscv_dmarb_p_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_c | gnt_p) begin
            state     <= ACCESS;
            req_we    <= gnt_p ? i_riscv_dmarb_p_we    : i_riscv_dmarb_c_we;
            req_sel   <= gnt_p ? i_riscv_dmarb_p_sel   : i_riscv_dmarb_c_sel;
            req_addr  <= gnt_p ? i_riscv_dmarb_p_addr  : i_riscv_dmarb_c_addr;
            req_wdata <= gnt_p ? i_riscv_dmarb_p_wdata : i_riscv_dmarb_c_wdata;
            req_owner <= gnt_p;
            last      <= gnt_p;
          end
        end
        ACCESS: begin
          state               <= IDLE;
          o_riscv_dmarb_rdata <= (~req_we & ~err) ? i_riscv_dmarb_dm_rdata : 64'd0;
          if (req_owner == PORT_P) begin
            o_riscv_dmarb_p_rvalid <= 1'b1;
            o_riscv_dmarb_p_err    <= err;
          end else begin
            o_riscv_dmarb_c_rvalid <= 1'b1;
            o_riscv_dmarb_c_err    <= err;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/riscv_dmarb.md
# riscv_dmarb

Two-port arbiter and access sequencer for the data memory. It shares the single memory port between the core load/store unit (port C) and the S-mode page-table walker (port P) using round-robin arbitration. Each granted request is registered and presented to the memory for exactly one cycle. Misaligned and out-of-range accesses are rejected with an error response and never reach the memory. The block sits between the LSU/PTW and the data memory, which reads combinationally and writes on the falling clock edge.

## Interface
- MEM_SIZE, 64, memory size in bytes; must match the data memory.
- i_riscv_dmarb_clk  in  1  clock; all state updates on the rising edge.
- i_riscv_dmarb_rst  in  1  reset, synchronous, active-high.
- i_riscv_dmarb_c_req / i_riscv_dmarb_p_req  in  1  request valid, per port.
- i_riscv_dmarb_c_we / i_riscv_dmarb_p_we  in  1  1 = store, 0 = load.
- i_riscv_dmarb_c_sel / i_riscv_dmarb_p_sel  in  2  access size: 00 = byte, 01 = half, 10 = word, 11 = double.
- i_riscv_dmarb_c_addr / i_riscv_dmarb_p_addr  in  64  byte address.
- i_riscv_dmarb_c_wdata / i_riscv_dmarb_p_wdata  in  64  store data, right-aligned.
- o_riscv_dmarb_c_gnt / o_riscv_dmarb_p_gnt  out  1  request accepted this cycle; combinational.
- o_riscv_dmarb_c_rvalid / o_riscv_dmarb_p_rvalid  out  1  one-cycle response pulse.
- o_riscv_dmarb_c_err / o_riscv_dmarb_p_err  out  1  error flag, qualified by rvalid.
- o_riscv_dmarb_rdata  out  64  response data, shared; qualified by the rvalid of the owning port.
- o_riscv_dmarb_dm_wen  out  1  memory write enable.
- o_riscv_dmarb_dm_sel  out  2  memory size select.
- o_riscv_dmarb_dm_addr  out  64  memory address.
- o_riscv_dmarb_dm_wdata  out  64  memory write data.
- i_riscv_dmarb_dm_rdata  in  64  memory read data.

## Operation
- FSM states:
  - IDLE: no access in progress.
  - ACCESS: a registered request is driving the memory.
- IDLE → ACCESS when any request is present. ACCESS → IDLE unconditionally.
- Grant happens only in IDLE, with at most one gnt per cycle. A requester holds req and its payload stable until it sees gnt. Req is ignored in ACCESS.
- Round-robin arbitration:
  - Pointer `last` records the last granted port.
  - If both ports request, grant the port that is not `last`.
  - A single requester always wins.
  - Reset value of `last` is P, so C wins the first contention.
- On grant, register we, sel, addr, wdata, and the owner into the request registers.
- Error check on the registered request (err = 1 when either holds):
  - Misalignment: sel = 01 with addr[0] ≠ 0; sel = 10 with addr[1:0] ≠ 0; sel = 11 with addr[2:0] ≠ 0.
  - Range: addr + (2^sel) − 1 ≥ MEM_SIZE. Compute with 65-bit arithmetic so the sum cannot wrap.
- Memory outputs:
  - dm_addr, dm_sel, and dm_wdata are driven from the request registers at all times.
  - dm_wen = (state == ACCESS) & we & ~err & ~rst.
- Response:
  - At the rising edge that ends ACCESS, rdata ← dm_rdata when (~we & ~err), else 0.
  - In the following cycle, the owner's rvalid = 1 and err = the computed error. The other port's rvalid = 0.
- Reset values: state = IDLE; `last` = P; all request registers = 0; both gnt = 0; both rvalid = 0; both err = 0; rdata = 0; dm_wen = 0.

## Timing
- Cycle 0: IDLE, req high → gnt = 1.
- Cycle 1: ACCESS; the store commits on the falling edge in this cycle.
- Cycle 2: rvalid = 1, back in IDLE. A new grant may occur in this same cycle.
- Load latency: 2 cycles from gnt to rvalid. Maximum throughput: one access per 2 cycles.
- Simultaneous requests in IDLE: exactly one gnt, chosen by round-robin. The losing port keeps req high and is granted at the next IDLE, 2 cycles later.
- Reset asserted while in ACCESS:
  - dm_wen drops in the same cycle, so no memory write occurs.
  - Next cycle: IDLE, with no rvalid.
- gnt depends on req in the same cycle. There is no combinational path from rdata into gnt.

## Test plan
- Core store, sel = 11, addr = 0x08, wdata = 0x1122334455667788. Then a core load of the same address. → dm_wen is high for exactly 1 cycle; the load returns 0x1122334455667788 with rvalid 2 cycles after gnt and err = 0.
- C and P request loads together from reset. → C is granted first and P 2 cycles later. With both held continuously, the grants alternate C, P, C, P.
- P store, sel = 10, addr = 0x06. → err = 1, dm_wen stays 0, memory contents are unchanged, and rdata = 0.
- C load, sel = 11, addr = 0x3C with MEM_SIZE = 64. → range error; addr = 0x38 succeeds. A load with addr = 0xFFFF_FFFF_FFFF_FFF8 → error, with no wrap.
- Reset pulsed during the ACCESS cycle of a store to 0x10 of 0xAB. → no write occurs, no rvalid appears, all outputs return to their reset values, and a later load of 0x10 returns 0.
- Back-to-back: C requests again in the same cycle its rvalid arrives. → gnt is asserted in that cycle, sustaining one access per 2 cycles.
